// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between two writeback
// requesters with round-robin priority and a registered write stage.
module rf_wb_arbiter #(
  parameter int N_REQ        = 2,
  parameter int ZERO_PROTECT = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             RegWrite,
  output logic [4:0]       Rd_Addr,
  output logic [31:0]      Rd_Data,
  output logic             last_grant,
  output logic [CNT_W-1:0] commit_cnt,
  input  logic             cnt_clr
);

  // PRI0 means requester 0 wins a tie, PRI1 means requester 1 wins a tie.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  pri_e             state_q;
  pri_e             state_d;
  logic [N_REQ-1:0] grant;
  logic             handshake;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;
  logic             write_next;

  // Priority register; reset to PRI0 so requester 0 is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRI0;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection and next priority: the requester just served drops to low priority.
  always_comb begin
    grant   = '0;
    state_d = state_q;
    case (state_q)
      PRI0: begin
        if (req0_valid) begin
          grant[0] = 1'b1;
        end else if (req1_valid) begin
          grant[1] = 1'b1;
        end
      end
      PRI1: begin
        if (req1_valid) begin
          grant[1] = 1'b1;
        end else if (req0_valid) begin
          grant[0] = 1'b1;
        end
      end
      default: begin
        grant = '0;
      end
    endcase
    if (grant[0]) begin
      state_d = PRI1;
    end else if (grant[1]) begin
      state_d = PRI0;
    end
  end

  // Ready is the grant itself, forced low while reset is held.
  assign req0_ready = grant[0] & rst_n;
  assign req1_ready = grant[1] & rst_n;

  // The last winner is implied by the priority state: PRI0 follows a grant to 1.
  assign last_grant = (state_q == PRI0);

  // Route the winner's payload towards the write stage.
  assign handshake  = |grant;
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;
  assign write_next = handshake && !((ZERO_PROTECT != 0) && (sel_addr == 5'd0));

  // Registered write stage: a handshake this cycle becomes a RF write next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      Rd_Addr  <= 5'd0;
      Rd_Data  <= 32'd0;
    end else begin
      RegWrite <= write_next;
      if (handshake) begin
        Rd_Addr <= sel_addr;
        Rd_Data <= sel_data;
      end
    end
  end

  // Saturating commit counter; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= '0;
    end else if (cnt_clr) begin
      commit_cnt <= '0;
    end else if (RegWrite && (commit_cnt != '1)) begin
      commit_cnt <= commit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table, corner-case sequences and a
// randomized run against a behavioural model of the writeback arbiter.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        RegWrite;
  logic [4:0]  Rd_Addr;
  logic [31:0] Rd_Data;
  logic        last_grant;
  logic [15:0] commit_cnt;
  logic        cnt_clr;

  int n_checks;
  int n_pass;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        exp_r0;
    logic        exp_r1;
    logic        exp_we;
    logic        chk_rd;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_lg;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[14];

  // Register file seen by the bench, written the same way the real RF would be.
  logic [31:0] rf [32];
  logic        rf_clear;

  // Behavioural model state for the randomized phase.
  int          m_last;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;
  logic        rv [2];
  logic [4:0]  ra [2];
  logic [31:0] rd [2];
  int          wait_cnt [2];
  int          win;
  logic        clr_r;

  rf_wb_arbiter #(.N_REQ(2), .ZERO_PROTECT(1), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .RegWrite   (RegWrite),
    .Rd_Addr    (Rd_Addr),
    .Rd_Data    (Rd_Data),
    .last_grant (last_grant),
    .commit_cnt (commit_cnt),
    .cnt_clr    (cnt_clr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-side register file committed at the end of every RegWrite cycle.
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (RegWrite) begin
      rf[Rd_Addr] <= Rd_Data;
    end
  end

  // Hard stop in case something stalls the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic r0, input logic r1, input logic we, input logic chk,
                              input logic [4:0] ea, input logic [31:0] ed,
                              input logic lg, input logic [15:0] cnt);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.exp_r0 = r0; v.exp_r1 = r1; v.exp_we = we; v.chk_rd = chk;
    v.exp_addr = ea; v.exp_data = ed; v.exp_lg = lg; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic clr);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    cnt_clr    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b1, 5'd9, 32'h1234, 1'b1, 5'd8, 32'h5678, 1'b0);
    #1;
    check_output("reset_ready0", {31'd0, req0_ready}, 32'd0);
    check_output("reset_ready1", {31'd0, req1_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_regwrite", {31'd0, RegWrite}, 32'd0);
    check_output("reset_rd_addr", {27'd0, Rd_Addr}, 32'd0);
    check_output("reset_rd_data", Rd_Data, 32'd0);
    check_output("reset_last_grant", {31'd0, last_grant}, 32'd1);
    check_output("reset_commit_cnt", {16'd0, commit_cnt}, 32'd0);
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rf_clear = 1'b1;

    // Directed vectors: inputs for cycle N, ready in N, registered outputs after the edge.
    vecs[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 16'd0);
    vecs[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 16'd1);
    vecs[2]  = mk(0, 5'd0, 32'h0,        1, 5'd9, 32'h99, 0, 1, 1, 1, 5'd9, 32'h99,       1, 16'd1);
    vecs[3]  = mk(1, 5'd3, 32'h11,       1, 5'd4, 32'h22, 1, 0, 1, 1, 5'd3, 32'h11,       0, 16'd2);
    vecs[4]  = mk(1, 5'd3, 32'h12,       1, 5'd4, 32'h22, 0, 1, 1, 1, 5'd4, 32'h22,       1, 16'd3);
    vecs[5]  = mk(1, 5'd3, 32'h12,       1, 5'd4, 32'h23, 1, 0, 1, 1, 5'd3, 32'h12,       0, 16'd4);
    vecs[6]  = mk(1, 5'd3, 32'h13,       1, 5'd4, 32'h23, 0, 1, 1, 1, 5'd4, 32'h23,       1, 16'd5);
    vecs[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 0, 1, 5'd4, 32'h23,       1, 16'd6);
    vecs[8]  = mk(1, 5'd1, 32'h55,       0, 5'd0, 32'h0,  1, 0, 1, 1, 5'd1, 32'h55,       0, 16'd6);
    vecs[9]  = mk(1, 5'd7, 32'hA,        1, 5'd7, 32'hB,  0, 1, 1, 1, 5'd7, 32'hB,        1, 16'd7);
    vecs[10] = mk(1, 5'd7, 32'hA,        0, 5'd0, 32'h0,  1, 0, 1, 1, 5'd7, 32'hA,        0, 16'd8);
    vecs[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 0, 1, 5'd7, 32'hA,        0, 16'd9);
    vecs[12] = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFF, 0, 1, 0, 0, 5'd0, 32'h0,      1, 16'd9);
    vecs[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 0, 0, 5'd0, 32'h0,        1, 16'd9);

    @(posedge clk);
    #1;
    rf_clear = 1'b0;
    do_reset();

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, 1'b0);
      @(negedge clk);
      check_output($sformatf("vec%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].exp_r0});
      check_output($sformatf("vec%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].exp_r1});
      tick();
      check_output($sformatf("vec%0d_regwrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].exp_we});
      if (vecs[i].chk_rd) begin
        check_output($sformatf("vec%0d_rd_addr", i), {27'd0, Rd_Addr}, {27'd0, vecs[i].exp_addr});
        check_output($sformatf("vec%0d_rd_data", i), Rd_Data, vecs[i].exp_data);
      end
      check_output($sformatf("vec%0d_last_grant", i), {31'd0, last_grant}, {31'd0, vecs[i].exp_lg});
      check_output($sformatf("vec%0d_commit_cnt", i), {16'd0, commit_cnt}, {16'd0, vecs[i].exp_cnt});
    end
    check_output("rf_r7_loser_final", rf[7], 32'hA);
    check_output("rf_r3_final", rf[3], 32'h12);
    check_output("rf_r4_final", rf[4], 32'h23);
    check_output("rf_r0_protected", rf[0], 32'h0);

    // Reset asserted between edges right after a handshake discards the pending write.
    $display("[TB] reset mid-operation");
    apply_stimulus(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("midrst_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    check_output("midrst_regwrite_before", {31'd0, RegWrite}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_regwrite_async", {31'd0, RegWrite}, 32'd0);
    check_output("midrst_ready0_in_reset", {31'd0, req0_ready}, 32'd0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_output("midrst_last_grant", {31'd0, last_grant}, 32'd1);
    check_output("midrst_commit_cnt", {16'd0, commit_cnt}, 32'd0);
    check_output("midrst_rf_r2_unwritten", rf[2], 32'h0);

    // Counter saturation and clear-over-increment.
    $display("[TB] commit counter saturation");
    apply_stimulus(1'b1, 5'd1, 32'hC0DE, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    tick();
    check_output("sat_cnt_fffe", {16'd0, commit_cnt}, 32'h0000FFFE);
    req0_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    tick();
    check_output("sat_cnt_ffff", {16'd0, commit_cnt}, 32'h0000FFFF);
    tick();
    check_output("sat_cnt_hold", {16'd0, commit_cnt}, 32'h0000FFFF);
    req0_valid = 1'b1;
    tick();
    check_output("clr_regwrite_high", {31'd0, RegWrite}, 32'd1);
    req0_valid = 1'b0;
    cnt_clr    = 1'b1;
    tick();
    check_output("clr_over_increment", {16'd0, commit_cnt}, 32'd0);
    cnt_clr = 1'b0;
    tick();
    check_output("clr_stays_zero", {16'd0, commit_cnt}, 32'd0);

    // Randomized traffic against the behavioural model.
    $display("[TB] randomized traffic");
    do_reset();
    m_last = 1;
    m_we   = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
    m_cnt  = 0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; ra[i] = 5'd0; rd[i] = 32'd0; wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && ($urandom_range(99) < 60)) begin
          rv[i]       = 1'b1;
          ra[i]       = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
          rd[i]       = $urandom;
          wait_cnt[i] = 0;
        end
      end
      clr_r = ($urandom_range(49) == 0);
      apply_stimulus(rv[0], ra[0], rd[0], rv[1], ra[1], rd[1], clr_r);
      if (rv[0] && rv[1]) win = (m_last == 1) ? 0 : 1;
      else if (rv[0])     win = 0;
      else if (rv[1])     win = 1;
      else                win = -1;
      @(negedge clk);
      check_output("rnd_ready0", {31'd0, req0_ready}, {31'd0, (win == 0)});
      check_output("rnd_ready1", {31'd0, req1_ready}, {31'd0, (win == 1)});
      tick();
      if (clr_r)                m_cnt = 0;
      else if (m_we && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_we = 1'b0;
      if (win >= 0) begin
        check_output("rnd_max_wait", wait_cnt[win], (wait_cnt[win] <= 1) ? wait_cnt[win] : 1);
        m_we   = (ra[win] != 5'd0);
        m_addr = ra[win];
        m_data = rd[win];
        m_last = win;
        rv[win] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (rv[i]) wait_cnt[i]++;
      end
      check_output("rnd_regwrite", {31'd0, RegWrite}, {31'd0, m_we});
      if (m_we) begin
        check_output("rnd_rd_addr", {27'd0, Rd_Addr}, {27'd0, m_addr});
        check_output("rnd_rd_data", Rd_Data, m_data);
      end
      check_output("rnd_last_grant", {31'd0, last_grant}, m_last);
      check_output("rnd_commit_cnt", {16'd0, commit_cnt}, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port (RegWrite / Rd_Addr / Rd_Data) between two writeback requesters, e.g. the ALU path (port 0) and the load/multi-cycle path (port 1).
Uses round-robin arbitration and a valid/ready handshake, and drives one registered write per cycle.
Also keeps a writes-committed counter for performance monitoring.

Parameters:
- N_REQ, 2, number of requesters; fixed at 2 for this revision.
- ZERO_PROTECT, 1, 1 means writes to address 0 are accepted but RegWrite is suppressed.
- CNT_W, 16, width of the commit counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  5  requester 0 destination register.
- req0_data  input  32  requester 0 write data.
- req0_ready  output  1  requester 0 handshake accepted this cycle.
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  5  requester 1 destination register.
- req1_data  input  32  requester 1 write data.
- req1_ready  output  1  requester 1 handshake accepted this cycle.
- RegWrite  output  1  write enable to the register file (registered).
- Rd_Addr  output  5  write address to the register file (registered).
- Rd_Data  output  32  write data to the register file (registered).
- last_grant  output  1  index of the most recent grant.
- commit_cnt  output  CNT_W  number of RegWrite pulses issued; saturating.
- cnt_clr  input  1  synchronous clear of commit_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous): RegWrite=0, Rd_Addr=0, Rd_Data=0, last_grant=1 (so requester 0 wins first), commit_cnt=0. req*_ready are combinational and read 0 while in reset.
- Priority FSM has two states, PRI0 and PRI1.
  - PRI0: requester 0 wins ties. PRI1: requester 1 wins ties.
  - State is PRI0 when last_grant=1, PRI1 when last_grant=0.
  - On any grant to i, last_grant <= i.
  - With no grant, state holds.
- Grant logic is combinational, one grant per cycle:
  - Only one valid: that requester is granted.
  - Both valid: the priority requester is granted.
  - Neither valid: no grant.
- reqX_ready = grantX. A handshake completes when valid & ready in the same cycle.
- The requester must hold valid, addr and data stable until ready. The arbiter never drops or reorders a held request.
- Latency: a handshake in cycle N produces RegWrite=1 with the captured addr/data in cycle N+1, so the RF writes at the end of N+1.
- With no handshake in cycle N, RegWrite=0 in N+1. Rd_Addr and Rd_Data hold their previous values.
- ZERO_PROTECT=1 and granted addr=0: the handshake completes (ready=1), RegWrite stays 0 next cycle, and commit_cnt does not increment. With ZERO_PROTECT=0, address 0 is written normally.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. Maximum wait is 1 cycle.
- Same address in the same cycle: the winner writes in N+1 and the loser in N+2, so the loser's data is final in the RF.
- commit_cnt increments by 1 on every cycle with RegWrite=1 and saturates at all-ones.
  - cnt_clr=1 forces 0 on the next edge and has priority over increment.
- Reset mid-operation: a pending registered write is discarded (RegWrite=0 immediately). Requesters must re-present after rst_n rises.
- No combinational path from the RF outputs back to the requester inputs.

Test Plan:
- Reset release, then req0_valid=1, addr=5, data=0xDEADBEEF -> req0_ready=1 in cycle 0; RegWrite=1, Rd_Addr=5, Rd_Data=0xDEADBEEF in cycle 1; commit_cnt=1.
- Both requesters valid for 4 cycles (r0: addr 3, data 0x11; r1: addr 4, data 0x22), with each advancing its data +1 after every handshake -> grants 0,1,0,1; RF sees writes 3/0x11, 4/0x22, 3/0x12, 4/0x23; last_grant ends at 1.
- Both valid to addr 7 (r0 data 0xA, r1 data 0xB) with last_grant=0 -> r1 granted first; r7 final value 0xA; two RegWrite pulses.
- req1 writes addr 0, data 0xFFFF, ZERO_PROTECT=1 -> req1_ready=1, RegWrite stays 0, commit_cnt unchanged.
- rst_n asserted low mid-cycle right after a handshake -> RegWrite drops to 0 asynchronously and no RF write occurs; after release, last_grant=1 and commit_cnt=0.
- Force commit_cnt to 0xFFFE, then 3 writes -> counter reads 0xFFFF and holds; cnt_clr=1 together with a write -> commit_cnt=0 next cycle.
